// File: rtl/mouse_pkt_framer.sv
// Assembles 3-byte PS/2 mouse packets from a UART byte stream and presents
// held button state plus saturated signed X/Y deltas with a one-cycle valid pulse.
module mouse_pkt_framer #(
    parameter int TIMEOUT_CYCLES = 100000,
    parameter bit INVERT_Y       = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    input  logic       rx_frame_err,
    output logic       btn_left,
    output logic       btn_right,
    output logic       btn_middle,
    output logic [7:0] delta_x,
    output logic [7:0] delta_y,
    output logic       data_valid,
    output logic       sync_err
);

    typedef enum logic [1:0] {WAIT_B0, WAIT_B1, WAIT_B2} state_t;

    localparam int CNT_W = ($clog2(TIMEOUT_CYCLES + 1) > 16) ? $clog2(TIMEOUT_CYCLES + 1) : 16;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic [2:0]       btn_q;
    logic [1:0]       sgn_q;
    logic [1:0]       ovf_q;
    logic [7:0]       x_q;
    logic             latch_hdr, latch_x;
    logic             vld_p0, err_p0;
    logic signed [7:0] dx_p0, dy_sat_p0, dy_p0;

    // Overflow flag forces the rail matching the sign; otherwise clamp the 9-bit value.
    function automatic logic signed [7:0] sat_delta(input logic sgn, input logic ovf,
                                                    input logic [7:0] mag);
        logic signed [8:0] raw;
        raw = {sgn, mag};
        if (ovf)
            sat_delta = sgn ? 8'sh80 : 8'sh7F;
        else if (raw > 9'sd127)
            sat_delta = 8'sh7F;
        else if (raw < -9'sd128)
            sat_delta = 8'sh80;
        else
            sat_delta = raw[7:0];
    endfunction

    function automatic logic signed [7:0] neg_sat(input logic signed [7:0] v);
        neg_sat = (v == 8'sh80) ? 8'sh7F : -v;
    endfunction

    always_comb begin
        dx_p0     = sat_delta(sgn_q[0], ovf_q[0], x_q);
        dy_sat_p0 = sat_delta(sgn_q[1], ovf_q[1], rx_data);
        dy_p0     = INVERT_Y ? neg_sat(dy_sat_p0) : dy_sat_p0;
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        latch_hdr = 1'b0;
        latch_x   = 1'b0;
        vld_p0    = 1'b0;
        err_p0    = 1'b0;
        if (rx_frame_err) begin
            state_nxt = WAIT_B0;
            cnt_nxt   = '0;
            err_p0    = 1'b1;
        end else begin
            case (state)
                WAIT_B0: begin
                    cnt_nxt = '0;
                    if (rx_valid) begin
                        if (rx_data[3]) begin
                            latch_hdr = 1'b1;
                            state_nxt = WAIT_B1;
                        end else begin
                            err_p0 = 1'b1;
                        end
                    end
                end
                WAIT_B1, WAIT_B2: begin
                    // An arriving byte beats a simultaneous timeout expiry.
                    if (rx_valid) begin
                        cnt_nxt = '0;
                        if (state == WAIT_B1) begin
                            latch_x   = 1'b1;
                            state_nxt = WAIT_B2;
                        end else begin
                            vld_p0    = 1'b1;
                            state_nxt = WAIT_B0;
                        end
                    end else if (cnt == CNT_LAST) begin
                        state_nxt = WAIT_B0;
                        cnt_nxt   = '0;
                        err_p0    = 1'b1;
                    end else begin
                        cnt_nxt = cnt + CNT_W'(1);
                    end
                end
                default: begin
                    state_nxt = WAIT_B0;
                    cnt_nxt   = '0;
                end
            endcase
        end
    end

    // Stage p0 -> p1: control and presented outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= WAIT_B0;
            cnt        <= '0;
            data_valid <= 1'b0;
            sync_err   <= 1'b0;
            btn_left   <= 1'b0;
            btn_right  <= 1'b0;
            btn_middle <= 1'b0;
            delta_x    <= '0;
            delta_y    <= '0;
        end else begin
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            data_valid <= vld_p0;
            sync_err   <= err_p0;
            if (vld_p0) begin
                btn_left   <= btn_q[0];
                btn_right  <= btn_q[1];
                btn_middle <= btn_q[2];
                delta_x    <= dx_p0;
                delta_y    <= dy_p0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (latch_hdr) begin
            btn_q <= rx_data[2:0];
            sgn_q <= rx_data[5:4];
            ovf_q <= rx_data[7:6];
        end
        if (latch_x)
            x_q <= rx_data;
    end

endmodule

// File: tb/tb_mouse_pkt_framer.sv
// Bench for mouse_pkt_framer: directed vector table, timeout corner sequences,
// and randomized traffic against a packet-level reference model.
module tb_mouse_pkt_framer;

    localparam int T = 50;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [7:0] rx_data = 8'h00;
    logic       rx_valid = 1'b0;
    logic       rx_frame_err = 1'b0;
    logic       btn_left, btn_right, btn_middle;
    logic [7:0] delta_x, delta_y;
    logic       data_valid, sync_err;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    mouse_pkt_framer #(.TIMEOUT_CYCLES(T), .INVERT_Y(1'b1)) dut (
        .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid),
        .rx_frame_err(rx_frame_err), .btn_left(btn_left), .btn_right(btn_right),
        .btn_middle(btn_middle), .delta_x(delta_x), .delta_y(delta_y),
        .data_valid(data_valid), .sync_err(sync_err)
    );

    always #5 clk = ~clk;

    // Reference model: bytes of the packet in progress, idle count, expected outputs
    logic [7:0] m_q[$];
    int         m_idle = 0;
    logic       m_dv = 1'b0, m_se = 1'b0;
    logic [2:0] m_btn = 3'b000;
    logic [7:0] m_dx = 8'h00, m_dy = 8'h00;

    function automatic int clamp8(input int v);
        return (v > 127) ? 127 : ((v < -128) ? -128 : v);
    endfunction

    function automatic int axis(input logic sgn, input logic ovf, input logic [7:0] b);
        int raw;
        raw = sgn ? int'(b) - 256 : int'(b);
        if (ovf) return sgn ? -128 : 127;
        return clamp8(raw);
    endfunction

    task automatic model_step(input logic r, input logic v, input logic f, input logic [7:0] d);
        logic [7:0] h;
        int xv, yv;
        m_dv = 1'b0;
        m_se = 1'b0;
        if (r) begin
            m_q.delete();
            m_idle = 0;
            m_btn = 3'b000; m_dx = 8'h00; m_dy = 8'h00;
        end else if (f) begin
            m_q.delete();
            m_idle = 0;
            m_se = 1'b1;
        end else if (v) begin
            m_idle = 0;
            if (m_q.size() == 0 && !d[3]) begin
                m_se = 1'b1;
            end else if (m_q.size() == 2) begin
                h  = m_q[0];
                xv = axis(h[4], h[6], m_q[1]);
                yv = clamp8(-axis(h[5], h[7], d));
                m_btn = h[2:0];
                m_dx  = xv[7:0];
                m_dy  = yv[7:0];
                m_dv  = 1'b1;
                m_q.delete();
            end else begin
                m_q.push_back(d);
            end
        end else if (m_q.size() != 0) begin
            m_idle++;
            if (m_idle == T) begin
                m_se = 1'b1;
                m_q.delete();
                m_idle = 0;
            end
        end
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s cyc=%0d got=%h exp=%h", name, cyc, got, exp);
        end
    endtask

    function automatic logic [22:0] outs();
        return {data_valid, sync_err, btn_middle, btn_right, btn_left, delta_x, delta_y};
    endfunction

    task automatic cycle(input logic r, input logic v, input logic f, input logic [7:0] d);
        rst = r; rx_valid = v; rx_frame_err = f; rx_data = d;
        @(posedge clk);
        #1;
        cyc++;
        model_step(r, v, f, d);
        chk("model", 32'(outs()), 32'({m_dv, m_se, m_btn, m_dx, m_dy}));
        chk("excl_dv_se", 32'(data_valid & sync_err), 32'd0);
        rst = 1'b0; rx_valid = 1'b0; rx_frame_err = 1'b0;
    endtask

    typedef struct {
        logic       r, v, f;
        logic [7:0] d;
        logic       dv, se;
        logic [2:0] btn;
        logic [7:0] dx, dy;
    } vec_t;

    vec_t vq[$];

    task automatic add(input logic r, v, f, input logic [7:0] d, input logic dv, se,
                       input logic [2:0] btn, input logic [7:0] dx, dy);
        vec_t e;
        e.r = r; e.v = v; e.f = f; e.d = d;
        e.dv = dv; e.se = se; e.btn = btn; e.dx = dx; e.dy = dy;
        vq.push_back(e);
    endtask

    initial begin
        logic [7:0] d;
        int r;
        // reset state
        add(1,0,0,8'h00, 0,0,3'b000,8'h00,8'h00);
        // 0x39 0xFB 0xFB with one idle cycle between bytes
        add(0,1,0,8'h39, 0,0,3'b000,8'h00,8'h00);
        add(0,0,0,8'h00, 0,0,3'b000,8'h00,8'h00);
        add(0,1,0,8'hFB, 0,0,3'b000,8'h00,8'h00);
        add(0,0,0,8'h00, 0,0,3'b000,8'h00,8'h00);
        add(0,1,0,8'hFB, 1,0,3'b001,8'hFB,8'h05);
        add(0,0,0,8'h00, 0,0,3'b001,8'hFB,8'h05);
        add(0,0,0,8'h00, 0,0,3'b001,8'hFB,8'h05);
        // back-to-back saturation packets
        add(0,1,0,8'h48, 0,0,3'b001,8'hFB,8'h05);
        add(0,1,0,8'h10, 0,0,3'b001,8'hFB,8'h05);
        add(0,1,0,8'h00, 1,0,3'b000,8'h7F,8'h00);
        add(0,1,0,8'h18, 0,0,3'b000,8'h7F,8'h00);
        add(0,1,0,8'h00, 0,0,3'b000,8'h7F,8'h00);
        add(0,1,0,8'h00, 1,0,3'b000,8'h80,8'h00);
        add(0,1,0,8'h08, 0,0,3'b000,8'h80,8'h00);
        add(0,1,0,8'h00, 0,0,3'b000,8'h80,8'h00);
        add(0,1,0,8'h80, 1,0,3'b000,8'h00,8'h81);
        // bad header then resync
        add(0,1,0,8'h05, 0,1,3'b000,8'h00,8'h81);
        add(0,1,0,8'h0A, 0,0,3'b000,8'h00,8'h81);
        add(0,1,0,8'h02, 0,0,3'b000,8'h00,8'h81);
        add(0,1,0,8'h01, 1,0,3'b010,8'h02,8'hFF);
        // frame error mid-packet
        add(0,1,0,8'h08, 0,0,3'b010,8'h02,8'hFF);
        add(0,1,1,8'h03, 0,1,3'b010,8'h02,8'hFF);
        add(0,1,0,8'h09, 0,0,3'b010,8'h02,8'hFF);
        add(0,1,0,8'h04, 0,0,3'b010,8'h02,8'hFF);
        add(0,1,0,8'h00, 1,0,3'b001,8'h04,8'h00);
        // reset mid-packet
        add(0,1,0,8'h08, 0,0,3'b001,8'h04,8'h00);
        add(0,1,0,8'h05, 0,0,3'b001,8'h04,8'h00);
        add(1,0,0,8'h00, 0,0,3'b000,8'h00,8'h00);
        add(0,1,0,8'h00, 0,1,3'b000,8'h00,8'h00);
        add(0,0,0,8'h00, 0,0,3'b000,8'h00,8'h00);

        for (int i = 0; i < vq.size(); i++) begin
            cycle(vq[i].r, vq[i].v, vq[i].f, vq[i].d);
            chk($sformatf("vec%0d", i), 32'(outs()),
                32'({vq[i].dv, vq[i].se, vq[i].btn, vq[i].dx, vq[i].dy}));
        end

        // Timeout: 50 idle cycles after byte1 aborts the packet
        cycle(0,1,0,8'h08);
        cycle(0,1,0,8'h03);
        for (int k = 1; k <= T; k++) begin
            cycle(0,0,0,8'h00);
            if (k == T - 1) chk("to_not_yet", 32'(sync_err), 32'd0);
        end
        chk("to_sync_err", 32'(sync_err), 32'd1);
        chk("to_no_dv", 32'(data_valid), 32'd0);
        cycle(0,0,0,8'h00);
        chk("to_pulse_1cyc", 32'(sync_err), 32'd0);
        cycle(0,1,0,8'h08);
        cycle(0,1,0,8'h01);
        cycle(0,1,0,8'h02);
        chk("to_recover", 32'({data_valid, delta_x, delta_y}), 32'({1'b1, 8'h01, 8'hFE}));

        // Byte arriving on the expiry cycle is accepted
        cycle(0,1,0,8'h08);
        cycle(0,1,0,8'h03);
        for (int k = 1; k < T; k++) cycle(0,0,0,8'h00);
        cycle(0,1,0,8'h00);
        chk("expiry_accept", 32'({data_valid, sync_err, delta_x, delta_y}),
            32'({1'b1, 1'b0, 8'h03, 8'h00}));

        // Randomized traffic
        for (int n = 0; n < 3000; n++) begin
            r = $urandom_range(0, 999);
            d = 8'($urandom);
            if (r < 3) begin
                cycle(1,0,0,8'h00);
            end else if (r < 8) begin
                repeat ($urandom_range(45, 55)) cycle(0,0,0,8'h00);
            end else if (r < 30) begin
                cycle(0, 1'($urandom_range(0, 1)), 1, d);
            end else if (r < 600) begin
                if ($urandom_range(0, 3) != 0) d[3] = 1'b1;
                cycle(0,1,0,d);
            end else begin
                cycle(0,0,0,8'h00);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
